instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  leave IDLE and begin fetching at pc=0.
REQ-005 SHALL have port imem_req  output  1  fetch request, held until acknowledged.
REQ-006 SHALL have port imem_addr  output  PC_W  fetch address, equal to pc.
REQ-007 SHALL have port imem_ack  input  1  fetch acknowledge; imem_data valid in the same cycle.
REQ-008 SHALL have port imem_data  input  16  fetched instruction.
REQ-009 SHALL have port ir  output  16  latched instruction register, feeding the field decoder.
REQ-010 SHALL have port alu_start  output  1  one-cycle pulse launching the ALU operation.
REQ-011 SHALL have port alu_done  input  1  ALU result and flags valid.
REQ-012 SHALL have port alu_flags  input  3  {N,Z,C} from the ALU, sampled on alu_done.
REQ-013 SHALL have port rf_we  output  1  one-cycle register-file write enable for ir[9:7].
REQ-014 SHALL have port flags  output  3  architectural {N,Z,C} register.
REQ-015 SHALL have port pc  output  PC_W  program counter.
REQ-016 SHALL have port halted  output  1  high while in HALT.

Function
REQ-017 SHALL implement the states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-018 IDLE: when start=1, SHALL set pc=0 and enter FETCH on the next cycle; otherwise SHALL stay in IDLE.
REQ-019 FETCH: SHALL assert imem_req=1 with imem_addr=pc.
REQ-020 FETCH: on imem_ack=1, SHALL load imem_data into ir and enter DECODE; a zero-wait-state ack in the first FETCH cycle is legal.
REQ-021 FETCH: SHALL hold ir, pc and imem_req unchanged while imem_ack=0, with no timeout.
REQ-022 DECODE: SHALL evaluate the condition field ir[15:14] against flags as follows: 00 always; 01 if Z; 10 if N; 11 if C.
REQ-023 DECODE, condition false: SHALL set pc=pc+1 and enter FETCH, with no alu_start and no rf_we.
REQ-024 DECODE, condition true, opcode ir[13:10]=1111 (HALT): SHALL enter HALT with pc unchanged.
REQ-025 DECODE, condition true, opcode 1110 (BRANCH): SHALL set pc=pc+sign-extended ir[6:0], truncated modulo 2^PC_W, and enter FETCH.
REQ-026 DECODE, condition true, any other opcode: SHALL pulse alu_start=1 for exactly one cycle, the cycle of entry into EXEC.
REQ-027 EXEC: SHALL wait for alu_done=1, then latch alu_flags into flags and enter WB.
REQ-028 EXEC: alu_done arriving in the same cycle as alu_start SHALL be ignored; only alu_done from the cycle after alu_start onward SHALL be accepted.
REQ-029 WB: SHALL assert rf_we=1 for exactly one cycle, set pc=pc+1 and enter FETCH.
REQ-030 pc SHALL wrap from 2^PC_W-1 to 0 on increment.
REQ-031 HALT: SHALL hold halted=1 and all state until rst_n=0; start SHALL be ignored while in HALT.
REQ-032 start asserted in any state other than IDLE SHALL be ignored.
REQ-033 Minimum latency: an ALU instruction with zero-wait ack and alu_done one cycle after alu_start SHALL take 4 cycles (FETCH, DECODE, EXEC, WB).

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, pc=0, ir=0, flags=0, imem_req=0, alu_start=0, rf_we=0 and halted=0, regardless of clock.
REQ-035 A reset during FETCH or EXEC SHALL abandon the transaction, and a late imem_ack or alu_done after reset SHALL be ignored in IDLE.

Verification
REQ-036 Reset, then start pulse, then zero-wait ack of 0x0012 (cond 00, opcode 0000) with alu_done=1 and alu_flags=3'b010 one cycle after alu_start -> imem_req at pc=0, one alu_start, one rf_we, flags=010, pc=1 after 4 cycles.
REQ-037 With flags Z=0, fetch 0x4000 (cond 01) -> no alu_start, no rf_we, pc increments by 1.
REQ-038 At pc=5, fetch BRANCH 0x387D (shift=0x7D=-3) -> pc=2; at pc=2^PC_W-1, an ALU instruction -> pc=0 after WB.
REQ-039 Hold imem_ack=0 for 7 cycles -> imem_req stays 1, imem_addr stable, ir unchanged, state remains FETCH.
REQ-040 Fetch 0x3C00 (HALT) -> halted=1 and pc frozen; a subsequent start has no effect; rst_n=0 clears halted=0.
REQ-041 Assert rst_n=0 mid-EXEC, then alu_done=1 after release -> state IDLE, no rf_we, flags=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit instructions, evaluates the
// condition field, then skips, branches, halts or runs one ALU op with write-back.
module instr_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     ir,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [2:0]      alu_flags,
  output logic            rf_we,
  output logic [2:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_BR   = 4'hE;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [15:0]     ir_nx;
  logic [2:0]      flags_nx;
  logic            cond_ok;

  // flags = {N,Z,C}
  always_comb begin
    case (ir[15:14])
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = flags[1];
      2'b10:   cond_ok = flags[2];
      default: cond_ok = flags[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      flags <= flags_nx;
    end
  end

  // alu_start is issued from DECODE so an ALU answering one cycle later is
  // caught in the first EXEC cycle; a done coincident with the start is never seen.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir;
    flags_nx  = flags;
    alu_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_nx    = '0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          ir_nx    = imem_data;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        if (!cond_ok) begin
          pc_nx    = pc + PC_W'(1);
          state_nx = FETCH;
        end else if (ir[13:10] == OP_HALT) begin
          state_nx = HALT;
        end else if (ir[13:10] == OP_BR) begin
          pc_nx    = PC_W'(pc + {{PC_W{ir[6]}}, ir[6:0]});
          state_nx = FETCH;
        end else begin
          alu_start = 1'b1;
          state_nx  = EXEC;
        end
      end
      EXEC: begin
        if (alu_done) begin
          flags_nx = alu_flags;
          state_nx = WB;
        end
      end
      WB: begin
        pc_nx    = pc + PC_W'(1);
        state_nx = FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign rf_we     = (state == WB);
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level program model feeds
// expected fetch addresses and write-backs; a monitor checks them as they happen.
module tb_instr_sequencer;
  localparam int PC_W = 8;
  localparam int MSZ  = 1 << PC_W;

  logic            clk = 0, rst_n = 1, start = 0;
  logic            imem_req, imem_ack = 0, alu_start, alu_done = 0, rf_we, halted;
  logic [PC_W-1:0] imem_addr, pc;
  logic [15:0]     imem_data = 0, ir;
  logic [2:0]      alu_flags = 0, flags;

  instr_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .alu_start(alu_start), .alu_done(alu_done), .alu_flags(alu_flags),
    .rf_we(rf_we), .flags(flags), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [MSZ];
  int          q_fetch[$];
  logic [18:0] q_wb[$];
  int          checks = 0, errors = 0;
  int          budget = 0, hold_left = 0, mem_wait = 0, alu_lo = 0, alu_hi = 0;
  bit          mon_en = 0, lat_chk = 0;
  int          cyc = 0, fetch_cyc = 0, n_start = 0, n_we = 0;
  bit          exp_halt;
  int          exp_pc, exp_alu, t;
  logic [2:0]  exp_flags;
  bit          saw_done, we_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event or expired bound, expected none", nm);
  endtask

  // Instruction memory: random wait states, optional forced stall, limited ack budget.
  int  wcnt = 0;
  bit  wpend = 0;
  always begin
    @(posedge clk); #1;
    imem_ack  = 0;
    imem_data = 16'($urandom);
    if (!imem_req) wpend = 0;
    else if (hold_left > 0) hold_left--;
    else if (budget > 0) begin
      if (!wpend) begin wpend = 1; wcnt = $urandom_range(mem_wait, 0); end
      if (wcnt == 0) begin
        imem_ack = 1; imem_data = mem[imem_addr]; budget--; wpend = 0;
      end else wcnt--;
    end
  end

  // ALU stub: result flags are ir[2:0]; junk done/flags in the start cycle.
  int         acnt = 0;
  logic [2:0] ares = 0;
  always begin
    @(posedge clk); #1;
    alu_done  = 0;
    alu_flags = 3'($urandom);
    if (acnt > 0) begin
      acnt--;
      if (acnt == 0) begin alu_done = 1; alu_flags = ares; end
    end
    if (alu_start) begin
      ares     = ir[2:0];
      acnt     = 1 + $urandom_range(alu_hi, alu_lo);
      alu_done = 1'($urandom);
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      cyc++;
      if (imem_req && imem_ack) begin
        if (q_fetch.size() == 0) bad("extra_fetch");
        else chk("fetch_addr", 32'(imem_addr), 32'(q_fetch.pop_front()));
        fetch_cyc = cyc;
      end
      if (alu_start) n_start++;
      if (rf_we) begin
        n_we++;
        if (q_wb.size() == 0) bad("extra_rf_we");
        else chk("wb_ir_flags", 32'({ir, flags}), 32'(q_wb.pop_front()));
        if (lat_chk) chk("alu_latency", 32'(cyc - fetch_cyc), 32'(3));
      end
    end
  end

  // Program-level reference: walks k fetches from pc=0 with flags=0.
  task automatic model(input int k);
    int p = 0, off;
    logic [2:0] f = 0;
    logic [15:0] w;
    bit take;
    q_fetch.delete(); q_wb.delete();
    exp_halt = 0; exp_alu = 0;
    for (int i = 0; i < k; i++) begin
      w = mem[p];
      q_fetch.push_back(p);
      case (w[15:14])
        2'd0: take = 1;
        2'd1: take = f[1];
        2'd2: take = f[2];
        default: take = f[0];
      endcase
      if (!take) p = (p + 1) % MSZ;
      else if (w[13:10] == 4'hF) begin exp_halt = 1; break; end
      else if (w[13:10] == 4'hE) begin
        off = w[6] ? int'(w[6:0]) - 128 : int'(w[6:0]);
        p = ((p + off) % MSZ + MSZ) % MSZ;
      end else begin
        f = w[2:0];
        q_wb.push_back({w, f});
        exp_alu++;
        p = (p + 1) % MSZ;
      end
    end
    exp_pc = p; exp_flags = f; budget = q_fetch.size();
  endtask

  task automatic do_reset();
    mon_en = 0; budget = 0; hold_left = 0; start = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic run_prog(input int k, input int hold);
    int tt = 0;
    do_reset();
    model(k);
    n_start = 0; n_we = 0; hold_left = hold; mon_en = 1;
    pulse_start();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(imem_req), 1);
      chk("hold_addr", 32'(imem_addr), 0);
      chk("hold_ir", 32'(ir), 0);
    end
    while ((q_fetch.size() != 0 || q_wb.size() != 0) && tt < 20000) begin
      @(negedge clk); tt++;
    end
    if (tt >= 20000) bad("run_timeout");
    repeat (2) @(negedge clk);
    chk("end_halted", 32'(halted), 32'(exp_halt));
    chk("end_pc", 32'(pc), 32'(exp_pc));
    chk("end_flags", 32'(flags), 32'(exp_flags));
    chk("n_alu_start", 32'(n_start), 32'(exp_alu));
    chk("n_rf_we", 32'(n_we), 32'(exp_alu));
    if (!exp_halt) chk("end_stall_req", 32'(imem_req), 1);
    mon_en = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_alu_start", 32'(alu_start), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_halted", 32'(halted), 0);
    @(posedge clk); #1 rst_n = 1;

    // Minimum-latency ALU instruction.
    mem[0] = 16'h0012; mem_wait = 0; alu_lo = 0; alu_hi = 0; lat_chk = 1;
    run_prog(1, 0);
    lat_chk = 0;

    // Conditional skip with Z=0.
    mem[0] = 16'h4000;
    run_prog(1, 0);

    // Backward branch from pc=5 to pc=2.
    for (int a = 0; a < 5; a++) mem[a] = 16'h4000;
    mem[5] = 16'h387D;
    run_prog(7, 0);

    // pc wrap after WB at the last address.
    for (int a = 0; a < MSZ - 1; a++) mem[a] = 16'h4000;
    mem[MSZ-1] = 16'h0001;
    run_prog(MSZ + 1, 0);

    // Seven-cycle fetch stall.
    mem[0] = 16'h0012; alu_hi = 2;
    run_prog(1, 7);

    // HALT freezes pc and ignores start; reset clears it.
    mem[0] = 16'h4000; mem[1] = 16'h3C00;
    run_prog(2, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("halt_after_start", 32'(halted), 1);
    chk("halt_pc_frozen", 32'(pc), 1);
    chk("halt_no_req", 32'(imem_req), 0);
    rst_n = 0;
    #1;
    chk("halt_rst_clear", 32'(halted), 0);
    chk("halt_rst_pc", 32'(pc), 0);
    @(posedge clk); #1 rst_n = 1;

    // Reset mid-EXEC; the late alu_done must not complete anything.
    do_reset();
    mem[0] = 16'h0012; alu_lo = 4; alu_hi = 4; budget = 1;
    pulse_start();
    t = 0;
    while (!alu_start && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) bad("no_alu_start");
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("exec_rst_flags", 32'(flags), 0);
    @(posedge clk); #1 rst_n = 1;
    saw_done = 0; we_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (alu_done) saw_done = 1;
      if (rf_we) we_seen = 1;
    end
    chk("late_done_seen", 32'(saw_done), 1);
    chk("late_no_rf_we", 32'(we_seen), 0);
    chk("late_flags", 32'(flags), 0);
    chk("late_idle_req", 32'(imem_req), 0);
    chk("late_pc", 32'(pc), 0);

    // Random programs.
    mem_wait = 2; alu_lo = 0; alu_hi = 3;
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < MSZ; a++) begin
        mem[a] = 16'($urandom);
        if (mem[a][13:10] == 4'hF && $urandom_range(3) != 0) mem[a][10] = 1'b0;
      end
      run_prog($urandom_range(60, 20), $urandom_range(3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
